// File: rtl/brd_eth_rx_framer.sv
// brd_eth_rx_framer
// Receive-side Ethernet framer. Strips preamble/SFD, checks CRC-32 and frame
// length, forwards frame bytes to the packet engine and flags each frame end
// as good or bad.
//
// Ports
//   clk              single clock, rising edge
//   rst_n            asynchronous active-low reset
//   phy_stream_i     {cke, frm, dat[7:0]} from the PHY; byte valid when cke=1
//   in_eth_stream_o  {cke, frm, dat[7:0]} to the packet engine
//   frm_good_o       one-cycle pulse at the end of an accepted frame
//   frm_bad_o        one-cycle pulse at the end of a rejected frame
//   rx_frame_cnt_o   saturating count of frm_good_o pulses
//   rx_err_cnt_o     saturating count of frm_bad_o pulses
//
// Configuration
//   BRD_RX_FCS_STRIP_EN  when defined, a 4-byte cke-qualified delay line
//                        withholds the trailing FCS (latency 4 cke bytes + 1
//                        clk); when undefined FCS is forwarded (latency 1 clk).

module brd_eth_rx_framer #(
    parameter int unsigned MIN_FRAME = 64,
    parameter int unsigned MAX_FRAME = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  phy_stream_i,
    output logic [9:0]  in_eth_stream_o,
    output logic        frm_good_o,
    output logic        frm_bad_o,
    output logic [15:0] rx_frame_cnt_o,
    output logic [15:0] rx_err_cnt_o
);

    localparam int unsigned CNT_W  = 11;
    localparam int unsigned CRC_W  = 32;
    localparam int unsigned STAT_W = 16;
    localparam int unsigned PRE_W  = 3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_PAYLOAD  = 3'd2;
    localparam logic [2:0] S_CHECK    = 3'd3;
    localparam logic [2:0] S_DROP     = 3'd4;

    localparam logic [7:0]       PRE_BYTE      = 8'h55;
    localparam logic [7:0]       SFD_BYTE      = 8'hD5;
    localparam logic [PRE_W-1:0] PRE_MAX       = PRE_W'(7);
    localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_MAX     = {STAT_W{1'b1}};
    localparam logic [CRC_W-1:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [CRC_W-1:0] CRC_POLY_REFL = 32'hEDB8_8320;
    // Residue in normal (MSB-first) bit order; the register runs reflected.
    localparam logic [CRC_W-1:0] CRC_RESIDUE   = 32'hC704_DD7B;

`ifdef BRD_RX_FCS_STRIP_EN
    localparam int unsigned DLY_W     = 32;
    localparam logic [2:0]  DLY_DEPTH = 3'd4;
`endif

    // Reflected CRC-32 update over one byte, LSB first.
    function automatic logic [CRC_W-1:0] crc32_byte(input logic [CRC_W-1:0] crc,
                                                    input logic [7:0]       d);
        logic [CRC_W-1:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [CRC_W-1:0] bit_rev32(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    logic              cke_c;
    logic              frm_c;
    logic [7:0]        dat_c;

    logic [2:0]        state_q,     state_d;
    logic              armed_q,     armed_d;
    logic [PRE_W-1:0]  pre_cnt_q,   pre_cnt_d;
    logic [CNT_W-1:0]  byte_cnt_q,  byte_cnt_d;
    logic [CRC_W-1:0]  crc_q,       crc_d;
    logic              out_cke_q,   out_cke_d;
    logic              out_frm_q,   out_frm_d;
    logic [7:0]        out_dat_q,   out_dat_d;
    logic              good_q,      good_d;
    logic              bad_q,       bad_d;
    logic [STAT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [STAT_W-1:0] err_cnt_q,   err_cnt_d;
`ifdef BRD_RX_FCS_STRIP_EN
    logic [DLY_W-1:0]  dly_q,       dly_d;
    logic [2:0]        dly_cnt_q,   dly_cnt_d;
`endif

    logic              fwd_c;
    logic [7:0]        fwd_dat_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic              len_ok_c;
    logic              crc_ok_c;
    logic              frame_ok_c;

    assign cke_c = phy_stream_i[9];
    assign frm_c = phy_stream_i[8];
    assign dat_c = phy_stream_i[7:0];

    assign cnt_inc_c  = (byte_cnt_q == CNT_MAX) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);
    assign len_ok_c   = (32'(byte_cnt_q) >= MIN_FRAME) && (32'(byte_cnt_q) <= MAX_FRAME);
    assign crc_ok_c   = (bit_rev32(crc_q) == CRC_RESIDUE);
    assign frame_ok_c = len_ok_c && crc_ok_c;

    // Next-state, datapath and output decode.
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        pre_cnt_d   = pre_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        crc_d       = crc_q;
        out_cke_d   = cke_c;
        out_frm_d   = out_frm_q;
        out_dat_d   = out_dat_q;
        good_d      = 1'b0;
        bad_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        fwd_c       = 1'b0;
        fwd_dat_c   = 8'h00;
`ifdef BRD_RX_FCS_STRIP_EN
        dly_d       = dly_q;
        dly_cnt_d   = dly_cnt_q;
`endif

        if (cke_c) begin
            if (!armed_q) begin
                // Out of reset: wait for an inter-frame gap so no partial frame is taken.
                state_d = S_IDLE;
                armed_d = !frm_c;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (frm_c) begin
                            if (dat_c == PRE_BYTE) begin
                                state_d   = S_PREAMBLE;
                                pre_cnt_d = PRE_W'(1);
                            end else begin
                                state_d = S_DROP;
                            end
                        end
                    end
                    S_PREAMBLE: begin
                        if (!frm_c) begin
                            state_d = S_DROP;
                        end else if (dat_c == PRE_BYTE) begin
                            if (pre_cnt_q == PRE_MAX) begin
                                state_d = S_DROP;
                            end else begin
                                pre_cnt_d = pre_cnt_q + PRE_W'(1);
                            end
                        end else if (dat_c == SFD_BYTE) begin
                            state_d    = S_PAYLOAD;
                            crc_d      = CRC_INIT;
                            byte_cnt_d = '0;
`ifdef BRD_RX_FCS_STRIP_EN
                            dly_cnt_d  = 3'd0;
`endif
                        end else begin
                            state_d = S_DROP;
                        end
                    end
                    S_PAYLOAD: begin
                        if (frm_c) begin
                            crc_d      = crc32_byte(crc_q, dat_c);
                            byte_cnt_d = cnt_inc_c;
                            if (32'(cnt_inc_c) > MAX_FRAME) begin
                                // Oversize: reject now, DROP swallows the rest silently.
                                state_d = S_DROP;
                                bad_d   = 1'b1;
                            end else begin
`ifdef BRD_RX_FCS_STRIP_EN
                                // Release the oldest byte only once four are held back.
                                dly_d = {dly_q[23:0], dat_c};
                                if (dly_cnt_q == DLY_DEPTH) begin
                                    fwd_c     = 1'b1;
                                    fwd_dat_c = dly_q[31:24];
                                end else begin
                                    dly_cnt_d = dly_cnt_q + 3'd1;
                                end
`else
                                fwd_c     = 1'b1;
                                fwd_dat_c = dat_c;
`endif
                            end
                        end else begin
                            state_d = S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        good_d = frame_ok_c;
                        bad_d  = !frame_ok_c;
                        // This cke byte may already open the next frame.
                        if (frm_c) begin
                            if (dat_c == PRE_BYTE) begin
                                state_d   = S_PREAMBLE;
                                pre_cnt_d = PRE_W'(1);
                            end else begin
                                state_d = S_DROP;
                            end
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    S_DROP: begin
                        if (!frm_c) begin
                            state_d = S_IDLE;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end

            out_frm_d = fwd_c;
            out_dat_d = fwd_c ? fwd_dat_c : 8'h00;
        end

        if (good_d && (frame_cnt_q != STAT_MAX)) begin
            frame_cnt_d = frame_cnt_q + STAT_W'(1);
        end
        if (bad_d && (err_cnt_q != STAT_MAX)) begin
            err_cnt_d = err_cnt_q + STAT_W'(1);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            armed_q     <= 1'b0;
            pre_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            crc_q       <= CRC_INIT;
            out_cke_q   <= 1'b0;
            out_frm_q   <= 1'b0;
            out_dat_q   <= 8'h00;
            good_q      <= 1'b0;
            bad_q       <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
`ifdef BRD_RX_FCS_STRIP_EN
            dly_q       <= '0;
            dly_cnt_q   <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            pre_cnt_q   <= pre_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            crc_q       <= crc_d;
            out_cke_q   <= out_cke_d;
            out_frm_q   <= out_frm_d;
            out_dat_q   <= out_dat_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
`ifdef BRD_RX_FCS_STRIP_EN
            dly_q       <= dly_d;
            dly_cnt_q   <= dly_cnt_d;
`endif
        end
    end

    assign in_eth_stream_o = {out_cke_q, out_frm_q, out_dat_q};
    assign frm_good_o      = good_q;
    assign frm_bad_o       = bad_q;
    assign rx_frame_cnt_o  = frame_cnt_q;
    assign rx_err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_brd_eth_rx_framer.sv
// Directed bench for brd_eth_rx_framer: builds frames with a locally computed
// FCS, queues the bytes that must come out, and compares against the stream.

module tb_brd_eth_rx_framer;

    localparam int unsigned MIN_F = 64;
    localparam int unsigned MAX_F = 1518;
`ifdef BRD_RX_FCS_STRIP_EN
    localparam int STRIP = 4;
`else
    localparam int STRIP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  phy;
    logic [9:0]  eth;
    logic        good;
    logic        bad;
    logic [15:0] fcnt;
    logic [15:0] ecnt;

    int          vecs = 0;
    int          errs = 0;
    int          good_seen = 0;
    int          bad_seen = 0;
    int          exp_good = 0;
    int          exp_bad = 0;
    int          exp_fcnt = 0;
    int          exp_ecnt = 0;
    int          idx = 0;
    int          idx_prev = 0;
    int          bad_at = -1;
    logic        cke_prev = 1'b0;
    logic        rst_prev = 1'b0;
    logic [7:0]  sb[$];
    string       step = "reset";

    always #5 clk = ~clk;

    brd_eth_rx_framer #(
        .MIN_FRAME (MIN_F),
        .MAX_FRAME (MAX_F)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .phy_stream_i    (phy),
        .in_eth_stream_o (eth),
        .frm_good_o      (good),
        .frm_bad_o       (bad),
        .rx_frame_cnt_o  (fcnt),
        .rx_err_cnt_o    (ecnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL [%s] %s: observed %0h expected %0h", step, tag, obs, exp);
        end
    endtask

    // Bit-serial Ethernet CRC: one data bit at a time, LSB first.
    function automatic logic [31:0] fcs_step(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB8_8320;
        end
        return c;
    endfunction

    // Output monitor: scoreboard pops, stream rules, pulse bookkeeping.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (rst_n && rst_prev) begin
            chk("cke_latency", 32'(eth[9]), 32'(cke_prev));
            if (eth[9] && eth[8]) begin
                vecs++;
                assert (sb.size() != 0) else begin
                    errs++;
                    $error("FAIL [%s] spurious_fwd: observed byte %02h expected no byte", step, eth[7:0]);
                end
                if (sb.size() != 0) begin
                    exp_b = sb.pop_front();
                    chk("fwd_byte", 32'(eth[7:0]), 32'(exp_b));
                end
            end
            if (!eth[8]) chk("dat_zero_frm0", 32'(eth[7:0]), 32'(0));
            if (good || bad) chk("good_bad_excl", 32'(good & bad), 32'(0));
            if (good) good_seen++;
            if (bad) begin
                bad_seen++;
                bad_at = idx_prev;
            end
        end
        cke_prev = phy[9];
        rst_prev = rst_n;
        idx_prev = idx;
    end

    task automatic drive(input logic frm, input logic [7:0] d, input int period, input int i);
        @(posedge clk); #2;
        phy = {1'b1, frm, d};
        idx = i;
        for (int p = 1; p < period; p++) begin
            @(posedge clk); #2;
            phy = {1'b0, frm, d};
        end
    endtask

    task automatic idle(input int n, input int period);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, period, 0);
    endtask

    // plen payload bytes + FCS; abort_at>0 pulses reset before that frame byte.
    task automatic send_frame(input int plen, input bit corrupt, input int period,
                              input int gap, input int abort_at);
        logic [7:0]  fr[$];
        logic [31:0] c;
        logic [7:0]  b;
        int          len;
        bit          aborted;
        c = 32'hFFFF_FFFF;
        aborted = 1'b0;
        for (int i = 0; i < plen; i++) begin
            b = 8'($urandom);
            fr.push_back(b);
            c = fcs_step(c, b);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
        if (corrupt) fr[10] = fr[10] ^ 8'h04;
        len = fr.size();

        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, period, 0);
        drive(1'b1, 8'hD5, period, 0);
        for (int k = 1; k <= len; k++) begin
            if (k == abort_at) begin
                @(posedge clk); #2;
                rst_n = 1'b0;
                #1;
                chk("rst_stream", 32'(eth), 32'(0));
                chk("rst_good", 32'(good), 32'(0));
                chk("rst_bad", 32'(bad), 32'(0));
                chk("rst_fcnt", 32'(fcnt), 32'(0));
                chk("rst_ecnt", 32'(ecnt), 32'(0));
                sb.delete();
                exp_fcnt = 0;
                exp_ecnt = 0;
                aborted  = 1'b1;
                repeat (2) @(posedge clk);
                #2;
                rst_n = 1'b1;
            end
            if (!aborted && k <= int'(MAX_F)) begin
                if (STRIP == 0) sb.push_back(fr[k-1]);
                else if (k > STRIP) sb.push_back(fr[k-1-STRIP]);
            end
            drive(1'b1, fr[k-1], period, k);
        end
        idle(gap, period);

        if (!aborted) begin
            if (!corrupt && len >= int'(MIN_F) && len <= int'(MAX_F)) begin
                exp_good++;
                exp_fcnt++;
            end else begin
                exp_bad++;
                exp_ecnt++;
            end
        end
    endtask

    task automatic check_end();
        repeat (4) @(posedge clk);
        #2;
        chk("good_pulses", 32'(good_seen), 32'(exp_good));
        chk("bad_pulses", 32'(bad_seen), 32'(exp_bad));
        chk("rx_frame_cnt", 32'(fcnt), 32'(exp_fcnt));
        chk("rx_err_cnt", 32'(ecnt), 32'(exp_ecnt));
        chk("bytes_left", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        phy   = 10'h000;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_stream", 32'(eth), 32'(0));
        chk("rst_good", 32'(good), 32'(0));
        chk("rst_bad", 32'(bad), 32'(0));
        chk("rst_fcnt", 32'(fcnt), 32'(0));
        chk("rst_ecnt", 32'(ecnt), 32'(0));
        rst_n = 1'b1;
        idle(4, 1);

        step = "good64";
        send_frame(60, 1'b0, 1, 6, 0);
        check_end();

        step = "crc_err";
        send_frame(60, 1'b1, 1, 6, 0);
        check_end();

        step = "runt40";
        send_frame(36, 1'b0, 1, 6, 0);
        check_end();

        step = "oversize1600";
        bad_at = -1;
        send_frame(1596, 1'b0, 1, 6, 0);
        check_end();
        chk("oversize_bad_at", 32'(bad_at), 32'(MAX_F + 1));

        step = "back_to_back";
        send_frame(60, 1'b0, 1, 1, 0);
        send_frame(100, 1'b0, 1, 6, 0);
        check_end();

        step = "cke_third";
        send_frame(60, 1'b0, 3, 6, 0);
        check_end();

        step = "rst_mid_frame";
        send_frame(60, 1'b0, 1, 6, 30);
        check_end();

        step = "after_reset";
        send_frame(60, 1'b0, 1, 6, 0);
        check_end();
        chk("post_rst_fcnt_one", 32'(fcnt), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
